// File: rtl/qpsk_mapper.sv
// QPSK mapper: turns I/Q words from the bit splitter into bipolar NRZ symbols
// and an 8-sample-per-symbol digital passband stream, mod = I*cos - Q*sin.
// A one-word holding buffer lets back-to-back words stream without gaps.
module qpsk_mapper #(
  parameter int NSYM      = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NSYM-1:0]        i_word,
  input  logic [NSYM-1:0]        q_word,
  input  logic                   word_valid,
  output logic                   word_ready,
  output logic [1:0]             sym_i,
  output logic [1:0]             sym_q,
  output logic signed [8:0]      mod_out,
  output logic                   out_valid,
  output logic                   sym_strobe,
  output logic                   word_done
);

  localparam int            SW       = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam logic [SW-1:0] LAST_SYM = SW'(NSYM - 1);

  // NRZ level encodings on sym_i / sym_q
  localparam logic [1:0] LVL_POS = 2'b01;
  localparam logic [1:0] LVL_NEG = 2'b11;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_next;
  logic              hold_full, hold_full_next;
  logic [NSYM-1:0]   hold_i, hold_q;
  logic [NSYM-1:0]   act_i, act_q;
  logic [2:0]        phase;
  logic [SW-1:0]     sym;
  logic              accept, load, last_sample;
  logic              cur_i, cur_q;
  logic signed [7:0] cos8, sin8;
  logic signed [8:0] cos9, sin9, i_term, q_term, mod_calc;

  // Quarter-wave-symmetric carrier tables, 8 samples per symbol period
  function automatic logic signed [7:0] cos_lut(input logic [2:0] k);
    case (k)
      3'd0:    return  8'sd127;
      3'd1:    return  8'sd90;
      3'd2:    return  8'sd0;
      3'd3:    return -8'sd90;
      3'd4:    return -8'sd127;
      3'd5:    return -8'sd90;
      3'd6:    return  8'sd0;
      default: return  8'sd90;
    endcase
  endfunction

  function automatic logic signed [7:0] sin_lut(input logic [2:0] k);
    case (k)
      3'd0:    return  8'sd0;
      3'd1:    return  8'sd90;
      3'd2:    return  8'sd127;
      3'd3:    return  8'sd90;
      3'd4:    return  8'sd0;
      3'd5:    return -8'sd90;
      3'd6:    return -8'sd127;
      default: return -8'sd90;
    endcase
  endfunction

  // word_ready is registered, so a drain and a refill can never share an edge
  assign accept      = word_valid && word_ready;
  assign last_sample = (state == RUN) && (phase == 3'd7) && (sym == LAST_SYM);
  assign hold_full_next = accept ? 1'b1 : (load ? 1'b0 : hold_full);

  // Next-state logic: decide when the holding buffer moves into the active register
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_sample) begin
          if (hold_full) load = 1'b1;
          else           state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Holding-buffer occupancy and the registered ready flag derived from it
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full  <= 1'b0;
      word_ready <= 1'b0;
    end else begin
      hold_full  <= hold_full_next;
      word_ready <= !hold_full_next;
    end
  end

  // Holding-buffer payload, captured only on a handshake
  always_ff @(posedge clk) begin
    // NOTE: payload needs no reset; it is only read while hold_full, which is reset.
    if (accept) begin
      hold_i <= i_word;
      hold_q <= q_word;
    end
  end

  // Phase/symbol counters and the active shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= 3'd0;
      sym   <= '0;
      act_i <= '0;
      act_q <= '0;
    end else if (load) begin
      phase <= 3'd0;
      sym   <= '0;
      act_i <= hold_i;
      act_q <= hold_q;
    end else if (state == RUN) begin
      phase <= phase + 3'd1;
      if (phase == 3'd7) begin
        sym   <= last_sample ? '0 : sym + SW'(1);
        act_i <= MSB_FIRST ? (act_i << 1) : (act_i >> 1);
        act_q <= MSB_FIRST ? (act_q << 1) : (act_q >> 1);
      end
    end
  end

  // Current bit pair and exact sample value (|result| <= 180, fits 9 bits)
  assign cur_i    = MSB_FIRST ? act_i[NSYM-1] : act_i[0];
  assign cur_q    = MSB_FIRST ? act_q[NSYM-1] : act_q[0];
  assign cos8     = cos_lut(phase);
  assign sin8     = sin_lut(phase);
  assign cos9     = {cos8[7], cos8};
  assign sin9     = {sin8[7], sin8};
  assign i_term   = cur_i ? cos9 : -cos9;
  assign q_term   = cur_q ? sin9 : -sin9;
  assign mod_calc = i_term - q_term;

  // Registered outputs; everything reads zero outside RUN
  always_ff @(posedge clk) begin
    if (rst || (state != RUN)) begin
      out_valid  <= 1'b0;
      sym_i      <= 2'b00;
      sym_q      <= 2'b00;
      mod_out    <= '0;
      sym_strobe <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      out_valid  <= 1'b1;
      sym_i      <= cur_i ? LVL_POS : LVL_NEG;
      sym_q      <= cur_q ? LVL_POS : LVL_NEG;
      mod_out    <= mod_calc;
      sym_strobe <= (phase == 3'd0);
      word_done  <= last_sample;
    end
  end

endmodule
